hc194_serial_feeder: RTL

- Upstream driver for the 4-bit universal shift register S_74HC194.
- Accepts a DATA_W-bit word over a valid/ready handshake and drives the register's S1/S0/Dsr/Dsl/D pins to shift the word in serially, one bit per CP cycle.
- Pulses nib_strobe each time the register's Q holds a complete, correctly ordered nibble, so a downstream consumer can capture Q.
- Both blocks share CP and CR.

---
 rtl/hc194_serial_feeder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hc194_serial_feeder.sv
// Serial feeder for a 74HC194 shift register: shifts a DATA_W-bit word in one bit per CP cycle.
// Define FEEDER_CLEAR_EN to parallel-load CLR_VAL into the register before each word.
module hc194_serial_feeder #(
   parameter int         DATA_W  = 8,
   parameter logic [3:0] CLR_VAL = 4'b0000
) (
   input  logic              CP,
   input  logic              CR,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              dir,
   output logic              S1,
   output logic              S0,
   output logic              Dsr,
   output logic              Dsl,
   output logic [3:0]        D,
   output logic              nib_strobe,
   output logic [1:0]        nib_idx,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      SHIFT = 2'd2
   } state_t;

   localparam logic [3:0] LAST = 4'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              dir_q, dir_d;
   logic [1:0]        s_q, s_d;
   logic              dsr_q, dsr_d;
   logic              dsl_q, dsl_d;
   logic [3:0]        d_q, d_d;
   logic              stb_q, stb_d;
   logic [1:0]        idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              rdy_q, rdy_d;
   logic              load_bit;
   logic [DATA_W-1:0] src;

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         s_q     <= 2'b00;
         dsr_q   <= 1'b0;
         dsl_q   <= 1'b0;
         d_q     <= 4'h0;
         stb_q   <= 1'b0;
         idx_q   <= 2'b00;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         dsr_q   <= dsr_d;
         dsl_q   <= dsl_d;
         d_q     <= d_d;
         stb_q   <= stb_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
      end
   end

   // Word and direction are only read after acceptance, so they need no reset.
   always_ff @(posedge CP) begin
      sh_q  <= sh_d;
      dir_q <= dir_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      dir_d    = dir_q;
      s_d      = 2'b00;
      dsr_d    = 1'b0;
      dsl_d    = 1'b0;
      d_d      = 4'h0;
      stb_d    = 1'b0;
      idx_d    = 2'b00;
      load_bit = 1'b0;
      src      = sh_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dir_d = dir;
               cnt_d = 4'd0;
`ifdef FEEDER_CLEAR_EN
               sh_d    = in_data;
               state_d = CLR;
`else
               src      = in_data;
               load_bit = 1'b1;
               state_d  = SHIFT;
`endif
            end
         end
         CLR: begin
            load_bit = 1'b1;
            state_d  = SHIFT;
         end
         SHIFT: begin
            // cnt_q is the bit the register takes on this edge; every fourth completes a nibble.
            if (cnt_q[1:0] == 2'b11) begin
               stb_d = 1'b1;
               idx_d = cnt_q[3:2];
            end
            if (cnt_q == LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d    = cnt_q + 4'd1;
               load_bit = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == CLR) begin
         s_d = 2'b11;
         d_d = CLR_VAL;
      end

      // dir=0 presents the MSB on Dsr; dir=1 presents the LSB on Dsl.
      if (load_bit) begin
         s_d   = dir_d ? 2'b10 : 2'b01;
         dsr_d = ~dir_d & src[DATA_W-1];
         dsl_d = dir_d & src[0];
         sh_d  = dir_d ? (src >> 1) : (src << 1);
      end

      busy_d = (state_d != IDLE);
      rdy_d  = (state_d == IDLE);
   end

   assign in_ready   = rdy_q;
   assign busy       = busy_q;
   assign S1         = s_q[1];
   assign S0         = s_q[0];
   assign Dsr        = dsr_q;
   assign Dsl        = dsl_q;
   assign D          = d_q;
   assign nib_strobe = stb_q;
   assign nib_idx    = idx_q;

endmodule
